// File: rtl/npu_seq_pkg.sv
// npu_seq_pkg: shared states, npu bus addresses and control bits for the conv1 sequencer
package npu_seq_pkg;
  typedef enum logic [3:0] {IDLE, CLR, FETCH, WRCOL, TRIG, RDREQ, RDCAP, WAIT, NEXT, FIN} state_t;
  localparam logic [15:0] ADDR_IMG = 16'h1000;
  localparam logic [15:0] ADDR_W = 16'h2000;
  localparam logic [15:0] ADDR_FCN = 16'h3000;
  localparam logic [15:0] ADDR_CTRL = 16'h4000;
  localparam logic [15:0] ADDR_DONE = 16'h5000;
  localparam logic [15:0] ADDR_RES = 16'h6000;
  localparam int CTRL_TRIG = 0;
  localparam int CTRL_NEXT = 1;
  localparam int CTRL_CLR = 3;
  localparam logic [31:0] CTRL_TRIG_W = 32'd1 << CTRL_TRIG;
  localparam logic [31:0] CTRL_NEXT_W = 32'd1 << CTRL_NEXT;
  localparam logic [31:0] CTRL_CLR_W = 32'd1 << CTRL_CLR;
endpackage

// File: rtl/npu_col_fetch.sv
// npu_col_fetch: reads K_H vertically stacked pixels and packs them into one column word
module npu_col_fetch
  import npu_seq_pkg::*;
#(
  parameter int K_H = 3,
  parameter int IN_W = 15,
  parameter int IMG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IMG_AW-1:0] base,
  input  logic [7:0]        img_rdata,
  output logic [IMG_AW-1:0] img_addr,
  output logic              ready,
  output logic [31:0]       col
);
  localparam logic [2:0] KL = 3'(K_H);
  logic act;
  logic [2:0] k;
  logic [31:0] word;
  // the last byte is still on img_rdata when ready is raised, so it is merged in here
  assign ready = act && k == KL;
  assign col = word | (32'(img_rdata) << (8 * (K_H - 1)));
  // k counts cycles since start: addresses go out for k<K_H, byte k-1 arrives at k
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= 1'b0;
      k <= '0;
      word <= '0;
      img_addr <= '0;
    end else if (start) begin
      act <= 1'b1;
      k <= '0;
      word <= '0;
      img_addr <= base;
    end else if (act) begin
      k <= k + 3'd1;
      act <= k != KL;
      if (k < KL - 3'd1) img_addr <= img_addr + IMG_AW'(IN_W);
      for (int i = 0; i < K_H - 1; i++)
        if (k == 3'(i + 1)) word[8*i +: 8] <= img_rdata;
    end
  end
endmodule

// File: rtl/npu_conv_seq.sv
// npu_conv_seq: runs a full conv1 sliding-window pass on the npu; NPU_SEQ_NEXT_STATE_EN adds a final advance-to-conv2 write
module npu_conv_seq
  import npu_seq_pkg::*;
#(
  parameter int K_H = 3,
  parameter int K_W = 3,
  parameter int IN_H = 16,
  parameter int IN_W = 15,
  parameter int IMG_AW = 8,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IMG_AW-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic              npu_ena,
  output logic              npu_wea,
  output logic [15:0]       npu_addr,
  output logic [31:0]       npu_wdata,
  input  logic [31:0]       npu_rdata,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic [7:0]        res_row,
  output logic [7:0]        res_col
);
  localparam int OUT_H = IN_H - K_H + 1;
`ifdef NPU_SEQ_NEXT_STATE_EN
  localparam bit FIN_WR = 1'b1;
`else
  localparam bit FIN_WR = 1'b0;
`endif
  state_t state, state_n, ret, ret_n;
  logic [7:0] r, c, r_n, c_n, wcnt;
  logic fin_w, adv, go, ready, fw, ena_n, wea_n;
  logic [15:0] addr_n;
  logic [31:0] wdata_n, col;
  logic [IMG_AW-1:0] base;
  npu_col_fetch #(.K_H(K_H), .IN_W(IN_W), .IMG_AW(IMG_AW)) u_fetch (
    .clk(clk),
    .rst(rst),
    .start(go),
    .base(base),
    .img_rdata(img_rdata),
    .img_addr(img_addr),
    .ready(ready),
    .col(col)
  );
  // window walk; NEXT is only a WAIT return tag, the column/row advance costs no cycle
  always_comb begin
    state_n = state;
    ret_n = ret;
    r_n = r;
    c_n = c;
    adv = 1'b0;
    case (state)
      IDLE: if (start && !done) begin
        state_n = CLR;
        r_n = '0;
      end
      CLR: begin
        state_n = WAIT;
        ret_n = FETCH;
        c_n = '0;
      end
      FETCH: if (ready) state_n = WRCOL;
      WRCOL: begin
        state_n = WAIT;
        ret_n = c >= 8'(K_W - 1) ? TRIG : NEXT;
      end
      TRIG: begin
        state_n = WAIT;
        ret_n = RDREQ;
      end
      RDREQ: state_n = RDCAP;
      RDCAP: adv = 1'b1;
      WAIT: if (wcnt == 8'(SETTLE - 1)) begin
        state_n = ret;
        adv = ret == NEXT;
      end
      FIN: begin
        state_n = (FIN_WR && !fin_w) ? WAIT : IDLE;
        ret_n = FIN;
      end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      if (c != 8'(IN_W - 1)) begin
        c_n = c + 8'd1;
        state_n = FETCH;
      end else if (r != 8'(OUT_H - 1)) begin
        r_n = r + 8'd1;
        state_n = CLR;
      end else state_n = FIN;
    end
  end
  // bus word for the state being entered, so registered bus outputs line up with the state
  always_comb begin
    fw = FIN_WR && state_n == FIN && !fin_w;
    ena_n = (state_n inside {CLR, WRCOL, TRIG, RDREQ}) || fw;
    wea_n = ena_n && state_n != RDREQ;
    addr_n = state_n == WRCOL ? ADDR_IMG : state_n == RDREQ ? ADDR_RES : ena_n ? ADDR_CTRL : '0;
    wdata_n = state_n == WRCOL ? col : state_n == CLR ? CTRL_CLR_W : state_n == TRIG ? CTRL_TRIG_W :
              fw ? CTRL_NEXT_W : '0;
    go = state_n == FETCH && state != FETCH;
    base = IMG_AW'(32'(r_n) * IN_W + 32'(c_n));
  end
  // state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ret <= IDLE;
      r <= '0;
      c <= '0;
      wcnt <= '0;
      fin_w <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      npu_ena <= 1'b0;
      npu_wea <= 1'b0;
      npu_addr <= '0;
      npu_wdata <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_row <= '0;
      res_col <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      r <= r_n;
      c <= c_n;
      wcnt <= (state == WAIT && state_n == WAIT) ? wcnt + 8'd1 : '0;
      fin_w <= state == IDLE ? 1'b0 : state == FIN ? 1'b1 : fin_w;
      busy <= state_n != IDLE;
      done <= state == FIN && state_n == IDLE;
      npu_ena <= ena_n;
      npu_wea <= wea_n;
      npu_addr <= addr_n;
      npu_wdata <= wdata_n;
      res_valid <= state == RDCAP;
      if (state == RDCAP) begin
        res_data <= npu_rdata;
        res_row <= r;
        res_col <= c - 8'(K_W - 1);
      end
    end
  end
endmodule

// File: tb/tb_npu_conv_seq.sv
// tb_npu_conv_seq: randomized scoreboard bench with an npu bus responder and a window-sum reference
module tb_npu_conv_seq;
  localparam int K_H = 3, K_W = 3, IN_H = 16, IN_W = 15, IMG_AW = 8, SETTLE = 2;
  localparam int OUT_H = IN_H - K_H + 1, OUT_W = IN_W - K_W + 1;
`ifdef NPU_SEQ_NEXT_STATE_EN
  localparam int LAT = 2426, NNX = 1;
`else
  localparam int LAT = 2423, NNX = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, npu_ena, npu_wea, res_valid;
  logic [IMG_AW-1:0] img_addr;
  logic [7:0] img_rdata = '0;
  logic [15:0] npu_addr;
  logic [31:0] npu_wdata, res_data;
  logic [31:0] npu_rdata = '0;
  logic [7:0] res_row, res_col;
  npu_conv_seq #(.K_H(K_H), .K_W(K_W), .IN_H(IN_H), .IN_W(IN_W), .IMG_AW(IMG_AW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .img_addr(img_addr), .img_rdata(img_rdata),
    .npu_ena(npu_ena), .npu_wea(npu_wea), .npu_addr(npu_addr), .npu_wdata(npu_wdata), .npu_rdata(npu_rdata),
    .res_valid(res_valid), .res_data(res_data), .res_row(res_row), .res_col(res_col)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] img [256];
  always @(posedge clk) img_rdata <= img[img_addr];
  int tests = 0, fails = 0;
  int n_clr, n_trig, n_next, n_res, stray, spacing_bad;
  int last_acc = -100, gap = 1;
  logic [31:0] win [K_W];
  logic [31:0] acc = '0, rd_val = '0;
  bit rd_pend = 1'b0;
  logic [31:0] col_q [$];
  logic [47:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_win(input int r, input int c);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < K_H; i++)
      for (int j = 0; j < K_W; j++)
        s += 32'(img[(r + i) * IN_W + c + j]) * 32'(j * K_H + i + 1);
    return s;
  endfunction

  // npu responder: column window, weighted sum on trigger, registered result read
  always @(negedge clk) begin
    npu_rdata = rd_pend ? rd_val : $urandom();
    rd_pend = 1'b0;
    if (npu_ena) begin
      if (cyc - last_acc < gap) spacing_bad++;
      last_acc = cyc;
      gap = npu_wea ? SETTLE + 1 : 2;
      if (!npu_wea) begin
        if (npu_addr == 16'h6000) begin
          rd_pend = 1'b1;
          rd_val = acc;
        end else stray++;
      end else if (npu_addr == 16'h1000) begin
        if (col_q.size() == 0) stray++;
        else chk("col_word", npu_wdata, col_q.pop_front());
        for (int j = 0; j < K_W - 1; j++) win[j] = win[j + 1];
        win[K_W - 1] = npu_wdata;
      end else if (npu_addr == 16'h4000) begin
        if (npu_wdata == 32'h8) begin
          n_clr++;
          for (int j = 0; j < K_W; j++) win[j] = '0;
        end else if (npu_wdata == 32'h1) begin
          n_trig++;
          acc = '0;
          for (int j = 0; j < K_W; j++)
            for (int i = 0; i < 4; i++) acc += 32'(win[j][8*i +: 8]) * 32'(j * K_H + i + 1);
        end else if (npu_wdata == 32'h2) n_next++;
        else stray++;
      end else stray++;
    end
  end

  // result monitor
  always @(negedge clk) begin
    if (res_valid) begin
      n_res++;
      if (exp_q.size() == 0) stray++;
      else chk("result", {res_row, res_col, res_data}, exp_q.pop_front());
    end
  end

  task automatic run_pass(input int busy_at, input int rst_at);
    int t0, el;
    logic [31:0] w;
    exp_q.delete();
    col_q.delete();
    n_clr = 0; n_trig = 0; n_next = 0; n_res = 0; spacing_bad = 0; stray = 0;
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < IN_W; c++) begin
        w = '0;
        for (int i = 0; i < K_H; i++) w[8*i +: 8] = img[(r + i) * IN_W + c];
        col_q.push_back(w);
      end
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++) exp_q.push_back({8'(r), 8'(c), ref_win(r, c)});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    el = 0;
    chk("busy_on", busy, 1);
    while (!done && el < LAT + 200) begin
      start = el == busy_at;
      if (el == rst_at) begin
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_ena", npu_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        rst = 1'b0;
        exp_q.delete();
        col_q.delete();
        repeat (5) @(negedge clk);
        chk("rst_idle", busy, 0);
        return;
      end
      @(negedge clk);
      el = cyc - t0;
    end
    chk("done_lat", el, LAT);
    chk("busy_off", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done", busy, 0);
    repeat (10) @(negedge clk);
    chk("n_res", n_res, OUT_H * OUT_W);
    chk("res_left", exp_q.size(), 0);
    chk("col_left", col_q.size(), 0);
    chk("n_clr", n_clr, OUT_H);
    chk("n_trig", n_trig, OUT_H * OUT_W);
    chk("n_next", n_next, NNX);
    chk("spacing", spacing_bad, 0);
    chk("stray", stray, 0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) img[k] = 8'(k);
    for (int j = 0; j < K_W; j++) win[j] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, res_valid, npu_ena, npu_wea}, 0);
    chk("rst_bus", {npu_addr, npu_wdata}, 0);
    chk("rst_img", img_addr, 0);
    chk("rst_res", {res_data, res_row, res_col}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_pass(-1, -1);
    for (int k = 0; k < 256; k++) img[k] = 8'($urandom());
    run_pass(100, -1);
    for (int k = 0; k < 256; k++) img[k] = 8'($urandom());
    run_pass(-1, 500);
    run_pass(-1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
